// File: rtl/uart_frame_commit_ctrl_pkg.sv
// Shared definitions for the UART frame commit controller: FSM states, default
// delimiter and the 9-bit FIFO word layout {sop, payload}.
package uart_frame_commit_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DISCARD
  } frameState_t;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;
  localparam int FIFO_W  = 9;
  localparam int SOP_BIT = 8;

  function automatic logic [FIFO_W-1:0] packWord(input logic sop, input logic [7:0] payload);
    logic [FIFO_W-1:0] word;
    word = '0;
    word[SOP_BIT] = sop;
    word[SOP_BIT-1:0] = payload;
    return word;
  endfunction

  function automatic logic lenLegal(input logic [7:0] len, input int unsigned maxLen);
    return (len != 8'd0) && (32'(len) <= maxLen);
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter: restarts on every byte, runs only while enabled and
// raises expired in the cycle that would make the TIMEOUT_CYC-th idle cycle.
module uart_idle_timer
  import uart_frame_commit_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic writeClk,
  input  logic resetN,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] idleCount;

  assign expired = enable && !restart && (idleCount == LAST);

  always_ff @(posedge writeClk or negedge resetN) begin
    if (!resetN) begin
      idleCount <= '0;
    end else if (restart || !enable || expired) begin
      idleCount <= '0;
    end else begin
      idleCount <= idleCount + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_commit_ctrl.sv
// Write-side sequencer: streams framed UART payload into a speculative FIFO and
// commits or rolls back each packet depending on checksum, errors, overflow or timeout.
module uart_frame_commit_ctrl
  import uart_frame_commit_ctrl_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              writeClk,
  input  logic              resetN,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  input  logic              rxErr,
  input  logic              almostFull,
  input  logic              clrCnt,
  output logic [FIFO_W-1:0] fifoData,
  output logic              fifoWriteEn,
  output logic              commitWrite,
  output logic              rollbackWrite,
  output logic              busy,
  output logic [CNT_W-1:0]  pktGoodCnt,
  output logic [CNT_W-1:0]  pktDropCnt
);

  frameState_t state;
  logic [7:0]  remaining;
  logic [7:0]  runSum;
  logic [7:0]  sumWithByte;
  logic        firstByte;
  logic        timeoutHit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sumWithByte = runSum + rxData;
  assign busy        = (state != IDLE);

  uart_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) idleTimer (
    .writeClk(writeClk),
    .resetN  (resetN),
    .restart (rxValid),
    .enable  (busy),
    .expired (timeoutHit)
  );

  // In DISCARD, remaining counts the bytes still to swallow, CSUM included.
  always_ff @(posedge writeClk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      remaining     <= '0;
      runSum        <= '0;
      firstByte     <= 1'b0;
      fifoData      <= '0;
      fifoWriteEn   <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      pktGoodCnt    <= '0;
      pktDropCnt    <= '0;
    end else begin
      fifoWriteEn   <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      if (clrCnt) begin
        pktGoodCnt <= '0;
        pktDropCnt <= '0;
      end

      if (rxValid) begin
        case (state)
          IDLE: begin
            if (!rxErr && rxData == SOF_BYTE) state <= LEN;
          end
          LEN: begin
            if (rxErr || !lenLegal(rxData, MAX_LEN)) begin
              state <= IDLE;
              if (!clrCnt) pktDropCnt <= satInc(pktDropCnt);
            end else begin
              remaining <= rxData;
              runSum    <= rxData;
              firstByte <= 1'b1;
              state     <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (rxErr) begin
              rollbackWrite <= 1'b1;
              state         <= IDLE;
              if (!clrCnt) pktDropCnt <= satInc(pktDropCnt);
            end else if (almostFull) begin
              rollbackWrite <= 1'b1;
              state         <= DISCARD;
              if (!clrCnt) pktDropCnt <= satInc(pktDropCnt);
            end else begin
              fifoWriteEn <= 1'b1;
              fifoData    <= packWord(firstByte, rxData);
              firstByte   <= 1'b0;
              runSum      <= sumWithByte;
              remaining   <= remaining - 1'b1;
              if (remaining == 8'd1) state <= CSUM;
            end
          end
          CSUM: begin
            state <= IDLE;
            if (!rxErr && sumWithByte == 8'd0) begin
              commitWrite <= 1'b1;
              if (!clrCnt) pktGoodCnt <= satInc(pktGoodCnt);
            end else begin
              rollbackWrite <= 1'b1;
              if (!clrCnt) pktDropCnt <= satInc(pktDropCnt);
            end
          end
          DISCARD: begin
            remaining <= remaining - 1'b1;
            if (remaining == 8'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (timeoutHit) begin
        state <= IDLE;
        if (!clrCnt) pktDropCnt <= satInc(pktDropCnt);
        if (state == PAYLOAD || state == CSUM) rollbackWrite <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_commit_ctrl.sv
// Self-checking bench: directed frames with literal expectations, then random
// traffic compared every cycle against a frame-level reference model.
module tb_uart_frame_commit_ctrl;

  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 1024;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0] SOF = 8'h7E;

  logic             writeClk = 1'b0;
  logic             resetN = 1'b0;
  logic [7:0]       rxData = 8'h00;
  logic             rxValid = 1'b0;
  logic             rxErr = 1'b0;
  logic             almostFull = 1'b0;
  logic             clrCnt = 1'b0;
  logic [8:0]       fifoData;
  logic             fifoWriteEn;
  logic             commitWrite;
  logic             rollbackWrite;
  logic             busy;
  logic [CNT_W-1:0] pktGoodCnt;
  logic [CNT_W-1:0] pktDropCnt;

  int total = 0;
  int bad = 0;
  logic [8:0] wrLog[$];

  // Reference model: where we are in the frame, plus the expected outputs.
  bit   mActive, mAwaitLen, mFirst;
  int   mPayloadLeft, mDiscardLeft, mSum, mIdle;
  bit   eWe, eCommit, eRollback, eBusy;
  logic [8:0] eData;
  int   eGood, eDrop;

  always #5 writeClk = ~writeClk;

  uart_frame_commit_ctrl #(
    .SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .writeClk(writeClk), .resetN(resetN), .rxData(rxData), .rxValid(rxValid),
    .rxErr(rxErr), .almostFull(almostFull), .clrCnt(clrCnt), .fifoData(fifoData),
    .fifoWriteEn(fifoWriteEn), .commitWrite(commitWrite), .rollbackWrite(rollbackWrite),
    .busy(busy), .pktGoodCnt(pktGoodCnt), .pktDropCnt(pktDropCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mActive = 0; mAwaitLen = 0; mFirst = 0;
    mPayloadLeft = 0; mDiscardLeft = 0; mSum = 0; mIdle = 0;
    eWe = 0; eCommit = 0; eRollback = 0; eBusy = 0; eData = '0;
    eGood = 0; eDrop = 0;
  endfunction

  function automatic void modelStep(input logic [7:0] d, input bit v, input bit e, input bit af, input bit clr);
    bit drop = 0;
    bit good = 0;
    eWe = 0; eCommit = 0; eRollback = 0;
    if (!mActive) begin
      mIdle = 0;
      if (v && !e && d == SOF) begin
        mActive = 1; mAwaitLen = 1;
      end
    end else if (v) begin
      mIdle = 0;
      if (mAwaitLen) begin
        mAwaitLen = 0;
        if (e || d == 0 || int'(d) > MAX_LEN) begin
          mActive = 0; drop = 1;
        end else begin
          mPayloadLeft = d; mSum = d; mFirst = 1;
        end
      end else if (mDiscardLeft > 0) begin
        mDiscardLeft--;
        if (mDiscardLeft == 0) mActive = 0;
      end else if (mPayloadLeft > 0) begin
        if (e) begin
          eRollback = 1; drop = 1; mActive = 0; mPayloadLeft = 0;
        end else if (af) begin
          eRollback = 1; drop = 1; mDiscardLeft = mPayloadLeft; mPayloadLeft = 0;
        end else begin
          eWe = 1; eData = {mFirst, d}; mFirst = 0;
          mSum = (mSum + int'(d)) % 256; mPayloadLeft--;
        end
      end else begin
        if (!e && (mSum + int'(d)) % 256 == 0) begin
          eCommit = 1; good = 1;
        end else begin
          eRollback = 1; drop = 1;
        end
        mActive = 0;
      end
    end else begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        drop = 1;
        if (!mAwaitLen && mDiscardLeft == 0) eRollback = 1;
        mActive = 0; mAwaitLen = 0; mPayloadLeft = 0; mDiscardLeft = 0;
      end
    end
    if (clr) begin
      eGood = 0; eDrop = 0;
    end else begin
      if (good && eGood < CNT_MAX) eGood++;
      if (drop && eDrop < CNT_MAX) eDrop++;
    end
    eBusy = mActive;
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge writeClk or negedge resetN);
      if (!resetN) modelReset();
      else modelStep(rxData, rxValid, rxErr, almostFull, clrCnt);
    end
  end

  initial begin
    forever begin
      @(negedge writeClk);
      checkOutput("fifoWriteEn", fifoWriteEn, eWe);
      checkOutput("commitWrite", commitWrite, eCommit);
      checkOutput("rollbackWrite", rollbackWrite, eRollback);
      checkOutput("busy", busy, eBusy);
      checkOutput("pktGoodCnt", pktGoodCnt, eGood);
      checkOutput("pktDropCnt", pktDropCnt, eDrop);
      if (eWe) checkOutput("fifoData", fifoData, eData);
      checkOutput("pulseExclusive",
                  (int'(fifoWriteEn) + int'(commitWrite) + int'(rollbackWrite)) > 1, 0);
      if (fifoWriteEn === 1'b1) wrLog.push_back(fifoData);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic e,
                               input logic af, input logic clr);
    rxData = d; rxValid = v; rxErr = e; almostFull = af; clrCnt = clr;
    @(posedge writeClk);
    #1;
    rxValid = 1'b0; rxErr = 1'b0; almostFull = 1'b0; clrCnt = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic e = 1'b0, input logic af = 1'b0);
    applyStimulus(d, 1'b1, e, af, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge writeClk);
      #1;
    end
  endtask

  task automatic randByte(input logic [7:0] d);
    logic e, af, clr;
    e   = ($urandom_range(0, 63) == 0);
    af  = ($urandom_range(0, 31) == 0);
    clr = ($urandom_range(0, 59) == 0);
    applyStimulus(d, 1'b1, e, af, clr);
    if ($urandom_range(0, 999) == 0) idleCycles(TIMEOUT + 3);
    else if ($urandom_range(0, 999) == 0) idleCycles(TIMEOUT - 1);
    else idleCycles($urandom_range(0, 2));
  endtask

  initial begin
    int base;
    idleCycles(3);
    checkOutput("resetOutputs",
                {fifoData, fifoWriteEn, commitWrite, rollbackWrite, busy, pktGoodCnt, pktDropCnt}, 0);
    resetN = 1'b1;
    idleCycles(2);

    // LEN 03 + 11 + 22 + 33 = 0x69, so 0x97 closes the sum to zero.
    base = wrLog.size();
    sendByte(8'h7E); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    checkOutput("goodNoEarlyCommit", commitWrite, 0);
    sendByte(8'h97);
    checkOutput("goodCommit", commitWrite, 1);
    checkOutput("goodCount", pktGoodCnt, 1);
    checkOutput("goodWriteCount", wrLog.size() - base, 3);
    checkOutput("goodWord0", wrLog[base], 9'h111);
    checkOutput("goodWord1", wrLog[base + 1], 9'h022);
    checkOutput("goodWord2", wrLog[base + 2], 9'h033);
    idleCycles(2);

    base = wrLog.size();
    sendByte(8'h7E); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    sendByte(8'h98);
    checkOutput("badCsumRollback", rollbackWrite, 1);
    checkOutput("badCsumNoCommit", commitWrite, 0);
    checkOutput("badCsumDrops", pktDropCnt, 1);
    checkOutput("badCsumWrites", wrLog.size() - base, 3);
    idleCycles(2);

    base = wrLog.size();
    sendByte(8'h7E); sendByte(8'h41);
    checkOutput("longLenNoRollback", rollbackWrite, 0);
    idleCycles(1);
    checkOutput("longLenDrops", pktDropCnt, 2);
    checkOutput("longLenIdle", busy, 0);
    checkOutput("longLenNoWrites", wrLog.size() - base, 0);
    sendByte(8'h7E); sendByte(8'h01); sendByte(8'h05); sendByte(8'hFA);
    checkOutput("afterLongLenCommit", commitWrite, 1);
    checkOutput("afterLongLenGood", pktGoodCnt, 2);
    idleCycles(2);

    base = wrLog.size();
    sendByte(8'h7E); sendByte(8'h04); sendByte(8'h01);
    sendByte(8'h02, 1'b0, 1'b1);
    checkOutput("overflowRollback", rollbackWrite, 1);
    checkOutput("overflowDrops", pktDropCnt, 3);
    sendByte(8'h03); sendByte(8'h04); sendByte(8'hF2);
    checkOutput("overflowNoCommit", commitWrite, 0);
    checkOutput("overflowIdle", busy, 0);
    checkOutput("overflowWrites", wrLog.size() - base, 1);
    checkOutput("overflowWord", wrLog[base], 9'h101);
    sendByte(8'h7E); sendByte(8'h01); sendByte(8'h05); sendByte(8'hFA);
    checkOutput("afterOverflowCommit", commitWrite, 1);
    checkOutput("afterOverflowGood", pktGoodCnt, 3);
    idleCycles(2);

    sendByte(8'h7E); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22);
    idleCycles(TIMEOUT - 1);
    checkOutput("timeoutNotYet", rollbackWrite, 0);
    checkOutput("timeoutStillBusy", busy, 1);
    idleCycles(1);
    checkOutput("timeoutRollback", rollbackWrite, 1);
    checkOutput("timeoutIdle", busy, 0);
    checkOutput("timeoutDrops", pktDropCnt, 4);
    idleCycles(2);

    sendByte(8'h7E); sendByte(8'h03);
    sendByte(8'h11, 1'b1);
    checkOutput("rxErrRollback", rollbackWrite, 1);
    checkOutput("rxErrDrops", pktDropCnt, 5);
    sendByte(8'h7E); sendByte(8'h03); sendByte(8'h11);
    checkOutput("midFrameNoPulse", rollbackWrite, 0);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midFrameResetOutputs",
                {fifoData, fifoWriteEn, commitWrite, rollbackWrite, busy, pktGoodCnt, pktDropCnt}, 0);
    idleCycles(2);
    checkOutput("resetHeldRollback", rollbackWrite, 0);
    resetN = 1'b1;
    idleCycles(1);

    sendByte(8'h7E); sendByte(8'h01); sendByte(8'h05); sendByte(8'hFA);
    checkOutput("backToBackFirst", commitWrite, 1);
    sendByte(8'h7E); sendByte(8'h01); sendByte(8'h05); sendByte(8'hFA);
    checkOutput("backToBackSecond", commitWrite, 1);
    checkOutput("backToBackGood", pktGoodCnt, 2);
    idleCycles(2);

    for (int f = 0; f < 150; f++) begin
      logic [7:0] lenByte;
      logic [7:0] b;
      logic [7:0] csum;
      int sum;
      if ($urandom_range(0, 7) == 0) randByte(8'($urandom_range(0, 255)));
      lenByte = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(1, MAX_LEN));
      randByte(SOF);
      randByte(lenByte);
      sum = lenByte;
      for (int i = 0; i < int'(lenByte); i++) begin
        b = 8'($urandom_range(0, 255));
        sum += b;
        randByte(b);
      end
      csum = ($urandom_range(0, 3) != 0) ? 8'((256 - (sum % 256)) % 256)
                                         : 8'($urandom_range(0, 255));
      randByte(csum);
    end
    idleCycles(TIMEOUT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
